// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/eret
// entry (freeze, one-cycle flush, new PC), and keeps stall perf/watchdog state.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          TIMEOUT    = 1024,
  parameter int          TO_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        perf_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  localparam logic [31:0]     ERET_TYPE = 32'h0000_000e;
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     new_pc_q, new_pc_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [TO_W-1:0] con_q, con_d;
  logic            to_q, to_d;
  logic [5:0]      stall_req;
  logic            exc_take, stall_inc;

  // A stalled stage also freezes every stage upstream of it.
  always_comb begin
    stall_req = 6'b000000;
    if      (stallreq_from_mem) stall_req = 6'b011111;
    else if (stallreq_from_ex)  stall_req = 6'b001111;
    else if (stallreq_from_id)  stall_req = 6'b000111;
    else if (stallreq_from_if)  stall_req = 6'b000011;
  end

  always_comb begin
    state_d   = IDLE;
    new_pc_d  = new_pc_q;
    exc_take  = (state_q == IDLE) && (excepttype_i != 32'h0);
    stall_inc = (state_q == IDLE) && (excepttype_i == 32'h0) && stall_req[0];
    stall     = 6'b000000;
    if (state_q == IDLE) begin
      stall = exc_take ? 6'b111111 : stall_req;
      if (exc_take) begin
        state_d  = FLUSH;
        new_pc_d = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VECTOR;
      end
    end
    if (!rst) stall = 6'b000000;
  end

  // perf_clr dominates; both counters saturate rather than wrap.
  always_comb begin
    cyc_d = cyc_q;
    con_d = con_q;
    to_d  = to_q;
    if (perf_clr) begin
      cyc_d = 32'h0;
      con_d = '0;
      to_d  = 1'b0;
    end else begin
      if (stall_inc && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'h1;
      if (!stall_inc)           con_d = '0;
      else if (con_q != TO_MAX) con_d = con_q + TO_W'(1);
      if (con_d == TO_MAX) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      new_pc_q <= 32'h0;
      cyc_q    <= 32'h0;
      con_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
      cyc_q    <= cyc_d;
      con_q    <= con_d;
      to_q     <= to_d;
    end
  end

  assign flush         = (state_q == FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_cycles  = cyc_q;
  assign stall_timeout = to_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed plan steps plus random traffic, all checked
// against a cycle-level behavioural model of the controller's rules.
module tb_pipe_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_if, rq_id, rq_ex, rq_mem;
  logic [31:0] exc, epc;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, stall_cycles;
  logic        stall_timeout;

  int cmp  = 0;
  int mism = 0;

  // behavioural model state
  bit          m_fl;
  logic [31:0] m_pc;
  logic [31:0] m_cyc;
  int          m_con;
  bit          m_to;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(rq_if), .stallreq_from_id(rq_id),
    .stallreq_from_ex(rq_ex), .stallreq_from_mem(rq_mem),
    .excepttype_i(exc), .cp0_epc_i(epc), .perf_clr(perf_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Highest stalling stage k (if=1..mem=4) freezes stages 0..k: 2^(k+1)-1.
  function automatic logic [5:0] exp_stall();
    int k;
    if (!rst || m_fl) return 6'd0;
    if (exc != 0) return 6'h3f;
    k = rq_mem ? 4 : rq_ex ? 3 : rq_id ? 2 : rq_if ? 1 : 0;
    return (k == 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_fl = 0; m_pc = 0; m_cyc = 0; m_con = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit inc;
    inc = !m_fl && exc == 0 && (rq_if | rq_id | rq_ex | rq_mem);
    if (!m_fl && exc != 0) begin
      m_fl = 1;
      m_pc = (exc == 32'he) ? epc : 32'h20;
    end else m_fl = 0;
    if (perf_clr) begin
      m_cyc = 0; m_con = 0; m_to = 0;
    end else begin
      if (inc && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      m_con = inc ? ((m_con + 1 > TO) ? TO : m_con + 1) : 0;
      if (m_con == TO) m_to = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall()));
    chk({tag, ".flush"}, 32'(flush), 32'(m_fl));
    if (m_fl) chk({tag, ".new_pc"}, new_pc, m_pc);
    chk({tag, ".cycles"}, stall_cycles, m_cyc);
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
  endtask

  // Check mid-cycle, advance the model with this cycle's inputs, cross the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic i, input logic d, input logic e, input logic m);
    rq_if = i; rq_id = d; rq_ex = e; rq_mem = m;
  endtask

  initial begin
    rst = 1'b0; set_req(0, 0, 0, 0);
    exc = 0; epc = 0; perf_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.cycles", stall_cycles, 32'h0);
    rq_id = 1'b1;
    #1 chk("rst.stall_masked", 32'(stall), 32'h0);
    rst = 1'b1;
    #1 chk("rel.stall_id", 32'(stall), 32'h07);
    cycle("rel");
    rq_id = 0; perf_clr = 1; cycle("clr0"); perf_clr = 0;

    // priority
    set_req(1, 1, 1, 1); cycle("prio_mem");
    rq_mem = 0;          cycle("prio_ex");
    rq_ex = 0;           cycle("prio_id");
    rq_id = 0;           cycle("prio_if");
    rq_if = 0;           cycle("prio_none");
    chk("prio.cycles4", stall_cycles, 32'd4);

    // syscall with concurrent mem stall
    exc = 32'h8; rq_mem = 1; cycle("sys_T");
    exc = 0; rq_mem = 0;
    chk("sys.flush", 32'(flush), 32'h1);
    chk("sys.pc", new_pc, 32'h20);
    chk("sys.stall_flush", 32'(stall), 32'h0);
    cycle("sys_T1");
    chk("sys.unflush", 32'(flush), 32'h0);
    chk("sys.cycles_same", stall_cycles, 32'd4);
    cycle("sys_T2");

    // eret followed by a held exception that must be dropped during flush
    epc = 32'h0040_0104; exc = 32'he; cycle("eret_T");
    chk("eret.pc", new_pc, 32'h0040_0104);
    exc = 32'h1; cycle("eret_T1");
    cycle("eret_T2");
    exc = 0;
    chk("eret.reflush", 32'(flush), 32'h1);
    chk("eret.vec", new_pc, 32'h20);
    cycle("eret_T3");

    // watchdog
    perf_clr = 1; cycle("wd_clr"); perf_clr = 0;
    rq_ex = 1;
    for (int i = 0; i < TO - 1; i++) cycle("wd_run");
    chk("wd.not_yet", 32'(stall_timeout), 32'h0);
    cycle("wd_last");
    rq_ex = 0;
    chk("wd.set", 32'(stall_timeout), 32'h1);
    cycle("wd_hold");
    chk("wd.sticky", 32'(stall_timeout), 32'h1);
    perf_clr = 1; cycle("wd_pclr"); perf_clr = 0;
    chk("wd.cleared", 32'(stall_timeout), 32'h0);
    chk("wd.cyc_cleared", stall_cycles, 32'h0);

    // asynchronous reset in the middle of the flush cycle
    exc = 32'h8; cycle("rf_T");
    exc = 0;
    #2 rst = 1'b0;
    #1;
    chk("rf.flush_drop", 32'(flush), 32'h0);
    chk("rf.stall", 32'(stall), 32'h0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    cycle("rf_idle1");
    cycle("rf_idle2");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_req(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 11) == 0)
        exc = ($urandom_range(0, 1) == 1) ? 32'he : 32'($urandom_range(1, 31));
      else exc = 0;
      epc = $urandom;
      perf_clr = 1'($urandom_range(0, 59) == 0);
      cycle("rnd");
    end
    set_req(0, 0, 0, 0); exc = 0; perf_clr = 0;
    cycle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
